sample_window_collector: RTL and testbench
==========================================

Name: sample_window_collector

Overview:
Upstream feeder for the 8-input averaging datapath (a..h, sa -> avg). Accepts a serial stream of 16-bit samples under a valid/ready handshake. Packs each group of 8 consecutive samples into a shadow buffer. Presents each completed window as eight parallel, registered words plus a constant shift amount, held stable until the consumer acknowledges. Double-buffered, so the next window fills while the current one is held.

Parameters:
DATAWIDTH, 16, sample and output word width (must match the averager input width)
SHAMT, 1, constant shift amount driven on sa (three cascaded shr stages by 1 give /8)

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  synchronous, active-high reset
in_data  input  DATAWIDTH  incoming sample
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  collector can accept a sample this cycle
a, b, c, d, e, f, g, h  output  DATAWIDTH each  window words; a = oldest (1st) sample, h = newest (8th)
sa  output  8  constant SHAMT, zero-extended to 8 bits
win_valid  output  1  a..h hold a complete window
win_ack  input  1  consumer has taken the window (meaningful only while win_valid = 1)
win_count  output  8  number of windows delivered to a..h, mod 256

Behaviour:
- One clock domain, Clk. Rst is synchronous and active-high; it has priority over every other input in the same cycle.
- Reset values:
  - a..h = 0, win_valid = 0, win_count = 0, in_ready = 0 while Rst is high.
  - Internal: shadow fill count = 0, state = FILL.
  - in_ready = 1 in the first cycle after Rst deasserts.
- Accept rule: a sample is taken on a rising edge where in_valid && in_ready. It is written to shadow slot fill_cnt (0..7), then fill_cnt increments.
- in_ready is a function of registered state only (1 in FILL, 0 in PEND). It has no combinational path from in_valid or win_ack.
- FSM states:
  - FILL: in_ready = 1.
    - On acceptance with fill_cnt = 7, if the output slot is free (win_valid = 0, or win_ack = 1 this cycle):
      - next edge: shadow slots 0..6 plus the current in_data load into a..h.
      - win_valid = 1, win_count += 1, fill_cnt = 0, stay in FILL.
    - Otherwise: the 8th sample is stored, fill_cnt is held at 8 (full), and the FSM moves to PEND.
  - PEND: in_ready = 0.
    - On win_ack = 1: next edge loads shadow into a..h, win_valid stays 1, win_count += 1, fill_cnt = 0, go to FILL.
- Consume with nothing pending: win_ack = 1 while win_valid = 1 and no transfer occurs -> win_valid = 0 next edge. a..h keep their last values.
- Simultaneous 8th-sample acceptance and win_ack: the transfer wins. win_valid stays 1 with no bubble, and the new window is visible the next cycle.
- win_ack with win_valid = 0 is ignored.
- a..h change only on a transfer edge. They never change while win_valid = 1 and win_ack = 0.
- win_count wraps 255 -> 0.
- sa is a constant SHAMT[7:0] at all times, including reset.
- Throughput: sustains 1 sample/cycle indefinitely if win_ack is asserted within 8 cycles of each win_valid.
- Latency: the 8th sample's acceptance edge is followed, on the next edge, by win_valid = 1.
- Rst mid-window: the partial window is discarded, the PEND window is lost, and win_valid drops to 0. The next accepted sample becomes slot 0 (a).
- No arithmetic is done here. Samples pass through unmodified (unsigned, DATAWIDTH bits). Zero extension to 32 bits is the averager's responsibility.

Test Plan:
- Reset then stream 1..8 on consecutive cycles, win_ack held 0 -> one cycle after the 8th sample: win_valid = 1, a..h = 1,2,...,8, sa = 1, win_count = 1. in_ready stays 1.
- Continue streaming 9..16 with no ack -> 16 stored, state PEND, in_ready = 0. a..h still 1..8. Pulse win_ack -> next edge: a..h = 9..16, win_valid = 1, win_count = 2, in_ready = 1.
- Stream 17..24 with win_ack asserted exactly on sample 24's acceptance edge -> no gap in win_valid, a..h = 17..24, win_count = 3, state stays FILL.
- Window pending, win_ack = 1 with no new window ready -> win_valid = 0 next cycle, a..h held. A win_ack pulse while win_valid = 0 changes nothing.
- Accept 5 samples (0xAAAA..), assert Rst one cycle, then stream 0x0001..0x0008 -> first window is exactly 0x0001..0x0008 and win_count = 1. in_valid with Rst = 1 is not accepted.
- Deliver 256 windows with immediate ack -> win_count wraps to 0. Samples 0xFFFF pass through as a..h = 0xFFFF.

Source files
------------

// File: rtl/sample_window_collector_if.sv
// Sample stream in, eight-word window out, for the averaging datapath feeder.
interface sample_window_collector_if #(
   parameter int unsigned DATAWIDTH = 16
);
   logic [DATAWIDTH-1:0] in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [DATAWIDTH-1:0] a, b, c, d, e, f, g, h;
   logic [7:0]           sa;
   logic                 win_valid;
   logic                 win_ack;
   logic [7:0]           win_count;

   // Producer of samples and consumer of windows.
   modport master (
      output in_data, in_valid, win_ack,
      input  in_ready, a, b, c, d, e, f, g, h, sa, win_valid, win_count
   );

   // The collector itself.
   modport slave (
      input  in_data, in_valid, win_ack,
      output in_ready, a, b, c, d, e, f, g, h, sa, win_valid, win_count
   );
endinterface

// File: rtl/sample_window_collector.sv
// Packs a serial sample stream into double-buffered 8-word windows.
// A shadow buffer fills while the previous window is held on a..h until acked.
module sample_window_collector #(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned SHAMT     = 1
) (
   input logic                     Clk,
   input logic                     Rst,
   sample_window_collector_if.slave bus
);

   typedef enum logic {FILL, PEND} state_t;

   state_t               state, state_nxt;
   logic [3:0]           fill_cnt, fill_cnt_nxt;
   logic [DATAWIDTH-1:0] shadow [8];
   logic [DATAWIDTH-1:0] win_q  [8];
   logic                 win_valid_q;
   logic [7:0]           win_count_q;

   logic                 in_ready_c;
   logic                 accept;
   logic                 last_sample;
   logic                 slot_free;
   logic                 xfer_in;
   logic                 xfer_pend;
   logic                 consume;

   // State register and shadow fill count.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= FILL;
         fill_cnt <= '0;
      end else begin
         state    <= state_nxt;
         fill_cnt <= fill_cnt_nxt;
      end
   end

   // Next-state and next fill count.
   always_comb begin
      state_nxt    = state;
      fill_cnt_nxt = fill_cnt;
      case (state)
         FILL: begin
            if (xfer_in) begin
               fill_cnt_nxt = '0;
            end else if (last_sample) begin
               fill_cnt_nxt = 4'd8;
               state_nxt    = PEND;
            end else if (accept) begin
               fill_cnt_nxt = fill_cnt + 4'd1;
            end
         end
         PEND: begin
            if (xfer_pend) begin
               fill_cnt_nxt = '0;
               state_nxt    = FILL;
            end
         end
         default: begin
            state_nxt    = FILL;
            fill_cnt_nxt = '0;
         end
      endcase
   end

   // Handshake and transfer decisions; ready depends only on state and reset.
   always_comb begin
      in_ready_c  = !Rst && (state == FILL);
      accept      = bus.in_valid && in_ready_c;
      last_sample = accept && (fill_cnt == 4'd7);
      slot_free   = !win_valid_q || bus.win_ack;
      // Completing a window while the output slot frees up in the same cycle
      // transfers directly, so win_valid stays high without a bubble.
      xfer_in     = last_sample && slot_free;
      xfer_pend   = (state == PEND) && win_valid_q && bus.win_ack;
      consume     = win_valid_q && bus.win_ack && !xfer_in && !xfer_pend;
   end

   // Shadow buffer writes and output window register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         win_q       <= '{default: '0};
         win_valid_q <= 1'b0;
         win_count_q <= '0;
      end else begin
         if (accept) begin
            shadow[fill_cnt[2:0]] <= bus.in_data;
         end
         if (xfer_in) begin
            win_q       <= '{shadow[0], shadow[1], shadow[2], shadow[3],
                             shadow[4], shadow[5], shadow[6], bus.in_data};
            win_valid_q <= 1'b1;
            win_count_q <= win_count_q + 8'd1;
         end else if (xfer_pend) begin
            win_q       <= shadow;
            win_valid_q <= 1'b1;
            win_count_q <= win_count_q + 8'd1;
         end else if (consume) begin
            win_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.a         = win_q[0];
   assign bus.b         = win_q[1];
   assign bus.c         = win_q[2];
   assign bus.d         = win_q[3];
   assign bus.e         = win_q[4];
   assign bus.f         = win_q[5];
   assign bus.g         = win_q[6];
   assign bus.h         = win_q[7];
   assign bus.sa        = 8'(SHAMT);
   assign bus.win_valid = win_valid_q;
   assign bus.win_count = win_count_q;

endmodule

// File: tb/tb_sample_window_collector.sv
// Bench for sample_window_collector: directed test-plan scenarios with literal
// expectations, then random traffic, all checked every cycle against a
// queue-based model of the window collector.
module tb_sample_window_collector;

   logic Clk;
   logic Rst;

   sample_window_collector_if #(.DATAWIDTH(16)) bus ();

   sample_window_collector #(.DATAWIDTH(16), .SHAMT(1)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Behavioural model: samples collected so far, the window on display.
   logic [15:0] m_fill [$];
   logic [15:0] m_out  [8];
   bit          m_valid;
   logic [7:0]  m_count;

   logic [15:0] dut_w [8];
   always_comb dut_w = '{bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h};

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update at each edge from the inputs being presented.
   always @(posedge Clk) begin
      bit ack_eff;
      bit acc;
      if (Rst) begin
         m_fill.delete();
         m_out   = '{default: '0};
         m_valid = 1'b0;
         m_count = '0;
      end else begin
         acc     = bus.in_valid && (m_fill.size() < 8);
         ack_eff = bus.win_ack && m_valid;
         if (acc) m_fill.push_back(bus.in_data);
         if (m_fill.size() == 8 && (ack_eff || !m_valid)) begin
            for (int i = 0; i < 8; i++) m_out[i] = m_fill[i];
            m_fill.delete();
            m_valid = 1'b1;
            m_count = m_count + 8'd1;
         end else if (ack_eff) begin
            m_valid = 1'b0;
         end
      end
   end

   // Cycle-by-cycle comparison, away from the active edge.
   always @(negedge Clk) begin
      check("in_ready", 32'(bus.in_ready), 32'(!Rst && (m_fill.size() < 8)));
      check("win_valid", 32'(bus.win_valid), 32'(m_valid));
      check("win_count", 32'(bus.win_count), 32'(m_count));
      check("sa", 32'(bus.sa), 32'd1);
      for (int i = 0; i < 8; i++) check("word", 32'(dut_w[i]), 32'(m_out[i]));
   end

   task automatic step(input logic r, input logic v, input logic [15:0] d, input logic ack);
      Rst          = r;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.win_ack  = ack;
      @(posedge Clk);
      #1;
   endtask

   task automatic lit_window(input string name, input int unsigned first);
      for (int i = 0; i < 8; i++) check(name, 32'(dut_w[i]), first + 32'(i));
   endtask

   initial begin
      Rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.win_ack  = 1'b0;
      step(1, 0, 16'h0, 0);
      step(1, 1, 16'h1234, 0);
      check("rst_valid", 32'(bus.win_valid), 0);
      check("rst_count", 32'(bus.win_count), 0);
      check("rst_ready", 32'(bus.in_ready), 0);
      check("rst_a", 32'(bus.a), 0);
      check("rst_sa", 32'(bus.sa), 1);

      // Stream 1..8, no ack.
      for (int i = 1; i <= 8; i++) step(0, 1, 16'(i), 0);
      check("t1_valid", 32'(bus.win_valid), 1);
      check("t1_count", 32'(bus.win_count), 1);
      check("t1_ready", 32'(bus.in_ready), 1);
      lit_window("t1_win", 1);

      // Stream 9..16 without ack: shadow full, collector stalls.
      for (int i = 9; i <= 16; i++) step(0, 1, 16'(i), 0);
      check("t2_ready_stall", 32'(bus.in_ready), 0);
      lit_window("t2_held", 1);
      step(0, 0, 16'h0, 1);
      check("t2_valid", 32'(bus.win_valid), 1);
      check("t2_count", 32'(bus.win_count), 2);
      check("t2_ready", 32'(bus.in_ready), 1);
      lit_window("t2_win", 9);

      // Stream 17..24 with ack exactly on the 8th acceptance.
      for (int i = 17; i <= 24; i++) step(0, 1, 16'(i), logic'(i == 24));
      check("t3_valid", 32'(bus.win_valid), 1);
      check("t3_count", 32'(bus.win_count), 3);
      check("t3_ready", 32'(bus.in_ready), 1);
      lit_window("t3_win", 17);

      // Consume with nothing pending, then a stray ack.
      step(0, 0, 16'h0, 1);
      check("t4_valid", 32'(bus.win_valid), 0);
      lit_window("t4_held", 17);
      step(0, 0, 16'h0, 1);
      check("t4_stray_valid", 32'(bus.win_valid), 0);
      check("t4_stray_count", 32'(bus.win_count), 3);

      // Partial window discarded by reset.
      for (int i = 0; i < 5; i++) step(0, 1, 16'hAAAA + 16'(i), 0);
      step(1, 1, 16'h5555, 0);
      check("t5_rst_ready", 32'(bus.in_ready), 0);
      check("t5_rst_count", 32'(bus.win_count), 0);
      for (int i = 1; i <= 8; i++) step(0, 1, 16'(i), 0);
      check("t5_count", 32'(bus.win_count), 1);
      lit_window("t5_win", 1);

      // 256 windows with ack held: counter wraps, all-ones passes through.
      step(1, 0, 16'h0, 0);
      for (int i = 0; i < 2048; i++) step(0, 1, 16'hFFFF, 1);
      check("t6_count", 32'(bus.win_count), 0);
      check("t6_valid", 32'(bus.win_valid), 1);
      check("t6_a", 32'(bus.a), 32'hFFFF);
      check("t6_h", 32'(bus.h), 32'hFFFF);

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         step(logic'($urandom_range(0, 299) == 0),
              logic'($urandom_range(0, 3) != 0),
              16'($urandom),
              logic'($urandom_range(0, 2) == 0));
      end
      step(0, 0, 16'h0, 0);
      step(0, 0, 16'h0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
